// File: rtl/cpu_dma_rx_sched.sv
// Round-robin drain of complete packets from CPU DMA queues into the DMA RX path.
// One cycle to grant, then one word per cycle while dma_rx_rdy is high; dma_rx_rdy low stalls with no timeout.
module cpu_dma_rx_sched #(
  parameter int NUM_QUEUES     = 4,
  parameter int DMA_DATA_WIDTH = 32,
  parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
  parameter int MAX_PKT_WORDS  = 512,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_QUEUES-1:0]                  q_pkt_avail,
  output logic [NUM_QUEUES-1:0]                  q_rd,
  input  logic [NUM_QUEUES*DMA_DATA_WIDTH-1:0]   q_rd_data,
  input  logic [NUM_QUEUES*DMA_CTRL_WIDTH-1:0]   q_rd_ctrl,
  input  logic                                   dma_rx_rdy,
  output logic                                   dma_rx_wr,
  output logic [DMA_DATA_WIDTH-1:0]              dma_rx_data,
  output logic [DMA_CTRL_WIDTH-1:0]              dma_rx_ctrl,
  output logic                                   dma_rx_sop,
  output logic                                   dma_rx_eop,
  output logic [$clog2(NUM_QUEUES)-1:0]          dma_rx_qid,
  output logic                                   busy,
  output logic                                   pkt_abort
);

  localparam int QW = $clog2(NUM_QUEUES);
  localparam int CW = $clog2(MAX_PKT_WORDS) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  state_t        state;
  logic [QW-1:0] last_grant;
  logic [CW-1:0] word_cnt;
  logic [GW-1:0] gap_cnt;

  logic          arb_found;
  logic [QW-1:0] arb_idx;
  logic [QW:0]   cand;
  logic          ctrl_eop;
  logic          at_limit;

  // Rotating search starting just after the last queue served.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      cand = {1'b0, last_grant} + (QW+1)'(i);
      if (cand >= (QW+1)'(NUM_QUEUES))
        cand = cand - (QW+1)'(NUM_QUEUES);
      if (!arb_found && q_pkt_avail[cand[QW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[QW-1:0];
      end
    end
  end

  assign dma_rx_data = q_rd_data[dma_rx_qid*DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
  assign dma_rx_ctrl = q_rd_ctrl[dma_rx_qid*DMA_CTRL_WIDTH +: DMA_CTRL_WIDTH];
  assign ctrl_eop    = |dma_rx_ctrl;
  assign at_limit    = (word_cnt == CW'(MAX_PKT_WORDS - 1));

  // Gated by reset so a packet interrupted by reset loses no further words.
  assign dma_rx_wr  = (state == XFER) && !reset && dma_rx_rdy;
  assign q_rd       = dma_rx_wr ? (NUM_QUEUES'(1) << dma_rx_qid) : '0;
  assign dma_rx_sop = dma_rx_wr && (word_cnt == '0);
  assign dma_rx_eop = dma_rx_wr && (ctrl_eop || at_limit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      dma_rx_qid <= '0;
      last_grant <= QW'(NUM_QUEUES - 1);
      word_cnt   <= '0;
      gap_cnt    <= '0;
      busy       <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_found) begin
            dma_rx_qid <= arb_idx;
            word_cnt   <= '0;
            state      <= XFER;
            busy       <= 1'b1;
          end
        end
        XFER: begin
          if (dma_rx_wr) begin
            if (dma_rx_eop) begin
              last_grant <= dma_rx_qid;
              word_cnt   <= '0;
              gap_cnt    <= '0;
              pkt_abort  <= !ctrl_eop;
              state      <= GAP;
            end else if (word_cnt != CW'(MAX_PKT_WORDS)) begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        // Holds off re-arbitration until the served queue's flag has caught up.
        GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_dma_rx_sched.sv
// Bench for cpu_dma_rx_sched: FWFT queues modelled as word lists whose pkt_avail flag lags by two cycles,
// scheduler behaviour checked per scenario and by a packet-level round-robin reference on random traffic.
module tb_cpu_dma_rx_sched;

  logic         clk;
  logic         reset;
  logic [3:0]   q_pkt_avail;
  logic [3:0]   q_rd;
  logic [127:0] q_rd_data;
  logic [15:0]  q_rd_ctrl;
  logic         dma_rx_rdy;
  logic         dma_rx_wr;
  logic [31:0]  dma_rx_data;
  logic [3:0]   dma_rx_ctrl;
  logic         dma_rx_sop;
  logic         dma_rx_eop;
  logic [1:0]   dma_rx_qid;
  logic         busy;
  logic         pkt_abort;

  cpu_dma_rx_sched #(
    .NUM_QUEUES(4), .DMA_DATA_WIDTH(32), .DMA_CTRL_WIDTH(4), .MAX_PKT_WORDS(8), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .q_pkt_avail(q_pkt_avail), .q_rd(q_rd),
    .q_rd_data(q_rd_data), .q_rd_ctrl(q_rd_ctrl), .dma_rx_rdy(dma_rx_rdy),
    .dma_rx_wr(dma_rx_wr), .dma_rx_data(dma_rx_data), .dma_rx_ctrl(dma_rx_ctrl),
    .dma_rx_sop(dma_rx_sop), .dma_rx_eop(dma_rx_eop), .dma_rx_qid(dma_rx_qid),
    .busy(busy), .pkt_abort(pkt_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] q_rd;
    logic [3:0] avail;
    logic       wr, sop, eop, busy, abort;
    logic [1:0] qid;
  } obs_t;

  typedef logic [39:0] beat_t;  // {qid, sop, eop, ctrl, data}

  logic [35:0] qm [4][$];       // queue contents, {ctrl, data}, head at index 0
  logic [3:0]  d0, d1, d2, force_av;
  obs_t        log_q[$];
  beat_t       beats[$];
  int          total, bad;

  function automatic beat_t mk_beat(input logic [1:0] q, input logic s, input logic e,
                                    input logic [3:0] c, input logic [31:0] d);
    return {q, s, e, c, d};
  endfunction

  function automatic logic [3:0] has_complete();
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < qm[i].size(); w++)
        if (qm[i][w][35:32] != 4'h0) r[i] = 1'b1;
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      if (qm[i].size() > 0) begin
        q_rd_data[i*32 +: 32] = qm[i][0][31:0];
        q_rd_ctrl[i*4 +: 4]   = qm[i][0][35:32];
      end else begin
        q_rd_data[i*32 +: 32] = '0;
        q_rd_ctrl[i*4 +: 4]   = '0;
      end
    end
    q_pkt_avail = d2 | force_av;
  endtask

  // One clock: sample at negedge, then pop and update queue inputs just after posedge.
  task automatic tick();
    obs_t       o;
    logic       do_pop;
    logic [1:0] pop_q;
    logic [3:0] exp_rd;
    do_pop = 1'b0;
    pop_q  = '0;
    @(negedge clk);
    o.q_rd = q_rd; o.avail = q_pkt_avail; o.wr = dma_rx_wr; o.sop = dma_rx_sop;
    o.eop = dma_rx_eop; o.busy = busy; o.abort = pkt_abort; o.qid = dma_rx_qid;
    log_q.push_back(o);
    exp_rd = dma_rx_wr ? (4'b0001 << dma_rx_qid) : 4'b0000;
    total++;
    if (q_rd !== exp_rd) begin
      bad++; $display("FAIL q_rd_strobe: got %b want %b", q_rd, exp_rd);
    end
    total++;
    if (dma_rx_wr === 1'b1 && dma_rx_rdy !== 1'b1) begin
      bad++; $display("FAIL wr_without_rdy: wr=%b rdy=%b", dma_rx_wr, dma_rx_rdy);
    end
    if (dma_rx_wr === 1'b1) begin
      total++;
      if (qm[dma_rx_qid].size() == 0) begin
        bad++; $display("FAIL read_empty_queue: qid=%0d", dma_rx_qid);
      end else if ({dma_rx_ctrl, dma_rx_data} !== qm[dma_rx_qid][0]) begin
        bad++; $display("FAIL head_word: got %h want %h", {dma_rx_ctrl, dma_rx_data}, qm[dma_rx_qid][0]);
      end else begin
        do_pop = 1'b1;
        pop_q  = dma_rx_qid;
      end
      beats.push_back(mk_beat(dma_rx_qid, dma_rx_sop, dma_rx_eop, dma_rx_ctrl, dma_rx_data));
    end
    @(posedge clk);
    #1;
    if (do_pop) void'(qm[pop_q].pop_front());
    d2 = d1; d1 = d0; d0 = has_complete();
    drive_inputs();
  endtask

  task automatic run_until_beats(input int n, input int budget, input string name);
    int k = 0;
    while (beats.size() < n && k < budget) begin
      tick(); k++;
    end
    total++;
    if (beats.size() < n) begin
      bad++; $display("FAIL %s_timeout: beats=%0d want %0d", name, beats.size(), n);
    end
  endtask

  task automatic load_pkt(input int q, input int len, input logic [3:0] last_ctrl);
    for (int w = 0; w < len; w++)
      qm[q].push_back({(w == len - 1) ? last_ctrl : 4'h0, 32'($urandom)});
  endtask

  task automatic start_test();
    reset = 1'b1; dma_rx_rdy = 1'b0; force_av = '0;
    for (int i = 0; i < 4; i++) qm[i].delete();
    d0 = '0; d1 = '0; d2 = '0;
    drive_inputs();
    repeat (3) tick();
    reset = 1'b0;
    log_q.delete(); beats.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; dma_rx_rdy = 1'b1; force_av = 4'hF;
    for (int i = 0; i < 4; i++) qm[i].delete();
    d0 = '0; d1 = '0; d2 = '0;
    qm[0].push_back({4'h1, 32'hA5A5_0001});
    qm[2].push_back({4'h2, 32'h5A5A_0002});
    drive_inputs();
    log_q.delete(); beats.delete();
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({log_q[k].q_rd, log_q[k].wr, log_q[k].sop, log_q[k].eop, log_q[k].qid,
           log_q[k].busy, log_q[k].abort} !== 11'h0) begin
        bad++; $display("FAIL reset_outputs: cycle %0d got %h want 0", k,
                        {log_q[k].q_rd, log_q[k].wr, log_q[k].qid, log_q[k].busy});
      end
    end
    force_av = '0; reset = 1'b0; drive_inputs();
    run_until_beats(2, 30, "reset_prio");
    // release at log index 4 arbitrates, first beat one cycle later
    total++;
    if (log_q.size() < 6 || log_q[5].wr !== 1'b1) begin
      bad++; $display("FAIL grant_latency: first beat not at cycle 5 (log size %0d)", log_q.size());
    end
    total++;
    if (beats.size() < 2 || beats[0] !== mk_beat(2'd0, 1'b1, 1'b1, 4'h1, 32'hA5A5_0001)) begin
      bad++; $display("FAIL reset_first_priority: got %h want %h", beats.size() > 0 ? beats[0] : '0,
                      mk_beat(2'd0, 1'b1, 1'b1, 4'h1, 32'hA5A5_0001));
    end
    total++;
    if (beats.size() < 2 || beats[1][39:38] !== 2'd2) begin
      bad++; $display("FAIL reset_second_grant: got qid %0d want 2", beats.size() > 1 ? beats[1][39:38] : 2'd3);
    end
  endtask

  task automatic test_single();
    int r = -1;
    logic [4:0] rd_hits;
    logic [2:0] sops, eops;
    logic [6:0] busys;
    start_test();
    dma_rx_rdy = 1'b1;
    qm[2].push_back({4'h0, 32'($urandom)});
    qm[2].push_back({4'h0, 32'($urandom)});
    qm[2].push_back({4'h8, 32'($urandom)});
    drive_inputs();
    run_until_beats(3, 30, "single");
    repeat (8) tick();
    for (int k = 0; k < log_q.size(); k++)
      if (r < 0 && log_q[k].avail[2]) r = k;
    total++;
    if (r < 0 || r + 6 >= log_q.size()) begin
      bad++; $display("FAIL single_request_seen: r=%0d", r);
    end else begin
      rd_hits = '0; sops = '0; eops = '0; busys = '0;
      for (int k = 0; k < 5; k++) rd_hits[k] = (log_q[r+k].q_rd == 4'b0100);
      for (int k = 0; k < 3; k++) begin
        sops[k] = log_q[r+1+k].sop; eops[k] = log_q[r+1+k].eop;
      end
      for (int k = 0; k < 7; k++) busys[k] = log_q[r+k].busy;
      total++;
      if (rd_hits !== 5'b01110) begin
        bad++; $display("FAIL single_q_rd_window: got %b want 01110", rd_hits);
      end
      total++;
      if (log_q[r+1].qid !== 2'd2) begin
        bad++; $display("FAIL single_qid: got %0d want 2", log_q[r+1].qid);
      end
      total++;
      if ({sops, eops} !== {3'b001, 3'b100}) begin
        bad++; $display("FAIL single_sop_eop: got sop=%b eop=%b want 001/100", sops, eops);
      end
      // busy from the first XFER cycle through both GAP cycles after eop
      total++;
      if (busys !== 7'b0111110) begin
        bad++; $display("FAIL single_busy: got %b want 0111110", busys);
      end
    end
  endtask

  task automatic test_round_robin();
    start_test();
    dma_rx_rdy = 1'b1;
    for (int i = 0; i < 4; i++) load_pkt(i, 1, 4'h1);
    drive_inputs();
    run_until_beats(4, 100, "rr_first");
    repeat (6) tick();
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      total++;
      if (beats[i][39:38] !== 2'(i)) begin
        bad++; $display("FAIL rr_order: beat %0d got qid %0d want %0d", i, beats[i][39:38], i);
      end
    end
    load_pkt(3, 1, 4'h1);
    load_pkt(0, 1, 4'h1);
    drive_inputs();
    run_until_beats(6, 100, "rr_wrap");
    total++;
    if (beats.size() < 6 || beats[4][39:38] !== 2'd0 || beats[5][39:38] !== 2'd3) begin
      bad++; $display("FAIL rr_wrap_order: got %0d,%0d want 0,3",
                      beats.size() > 4 ? beats[4][39:38] : 2'd3, beats.size() > 5 ? beats[5][39:38] : 2'd3);
    end
  endtask

  task automatic test_backpressure();
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int k = 0;
    logic [3:0] sops, eops;
    start_test();
    load_pkt(1, 4, 4'h2);
    drive_inputs();
    while (k < 20 && !(log_q.size() > 0 && log_q[log_q.size()-1].busy)) begin
      tick(); k++;
    end
    for (int p = 0; p < 7; p++) begin
      dma_rx_rdy = pat[p][0];
      tick();
      total++;
      if (log_q[log_q.size()-1].wr !== pat[p][0] || log_q[log_q.size()-1].qid !== 2'd1) begin
        bad++; $display("FAIL bp_beat: step %0d got wr=%b qid=%0d want wr=%0d qid=1",
                        p, log_q[log_q.size()-1].wr, log_q[log_q.size()-1].qid, pat[p]);
      end
    end
    dma_rx_rdy = 1'b1;
    repeat (5) tick();
    total++;
    if (beats.size() !== 4) begin
      bad++; $display("FAIL bp_beat_count: got %0d want 4", beats.size());
    end else begin
      for (int b = 0; b < 4; b++) begin sops[b] = beats[b][37]; eops[b] = beats[b][36]; end
      total++;
      if ({sops, eops} !== {4'b0001, 4'b1000}) begin
        bad++; $display("FAIL bp_sop_eop: got sop=%b eop=%b want 0001/1000", sops, eops);
      end
    end
  endtask

  task automatic test_stale_flag();
    int e;
    int extra = 0;
    start_test();
    dma_rx_rdy = 1'b1;
    load_pkt(1, 2, 4'h3);
    drive_inputs();
    run_until_beats(2, 30, "stale");
    e = log_q.size() - 1;
    repeat (12) tick();
    for (int k = e + 1; k < log_q.size(); k++)
      if (log_q[k].q_rd != 4'b0000) extra++;
    total++;
    if (extra !== 0 || beats.size() !== 2) begin
      bad++; $display("FAIL stale_regrant: got %0d strobes after eop, %0d beats, want 0 and 2", extra, beats.size());
    end
    total++;
    if (log_q[e+3].busy !== 1'b0) begin
      bad++; $display("FAIL stale_idle: busy=%b three cycles after eop, want 0", log_q[e+3].busy);
    end
  endtask

  task automatic test_abort();
    int k = 0;
    int e;
    int aborts = 0;
    logic [7:0] sops, eops;
    start_test();
    dma_rx_rdy = 1'b1;
    load_pkt(3, 10, 4'h0);
    force_av = 4'b1000;
    drive_inputs();
    while (k < 40 && !(log_q.size() > 0 && log_q[log_q.size()-1].eop)) begin
      tick(); k++;
    end
    force_av = '0;
    drive_inputs();
    e = log_q.size() - 1;
    repeat (10) tick();
    for (int j = 0; j < log_q.size(); j++) if (log_q[j].abort) aborts++;
    total++;
    if (beats.size() !== 8) begin
      bad++; $display("FAIL abort_beat_count: got %0d want 8", beats.size());
    end else begin
      for (int b = 0; b < 8; b++) begin sops[b] = beats[b][37]; eops[b] = beats[b][36]; end
      total++;
      if ({sops, eops} !== {8'h01, 8'h80}) begin
        bad++; $display("FAIL abort_sop_eop: got sop=%b eop=%b want 01/80 hex", sops, eops);
      end
    end
    total++;
    if (aborts !== 1 || log_q[e+1].abort !== 1'b1) begin
      bad++; $display("FAIL abort_pulse: got %0d pulses, cycle after eop=%b, want 1 and 1", aborts, log_q[e+1].abort);
    end
    total++;
    if ({log_q[e+1].busy, log_q[e+2].busy, log_q[e+3].busy} !== 3'b110 || qm[3].size() !== 2) begin
      bad++; $display("FAIL abort_gap_idle: busy=%b left=%0d want 110 and 2",
                      {log_q[e+1].busy, log_q[e+2].busy, log_q[e+3].busy}, qm[3].size());
    end
  endtask

  task automatic test_reset_mid_packet();
    start_test();
    dma_rx_rdy = 1'b1;
    load_pkt(1, 1, 4'h1);
    drive_inputs();
    run_until_beats(1, 30, "mid_warmup");
    repeat (6) tick();
    load_pkt(2, 5, 4'h4);
    drive_inputs();
    run_until_beats(3, 30, "mid_partial");
    reset = 1'b1;
    load_pkt(0, 1, 4'h2);
    drive_inputs();
    tick();
    total++;
    if (log_q[log_q.size()-1].q_rd !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_strobe: got %b want 0000", log_q[log_q.size()-1].q_rd);
    end
    repeat (3) tick();
    total++;
    if ({log_q[log_q.size()-1].q_rd, log_q[log_q.size()-1].wr, log_q[log_q.size()-1].qid,
         log_q[log_q.size()-1].busy, log_q[log_q.size()-1].abort} !== 9'h0 || qm[2].size() !== 3) begin
      bad++; $display("FAIL mid_reset_state: outputs %h left=%0d want 0 and 3",
                      {log_q[log_q.size()-1].q_rd, log_q[log_q.size()-1].qid, log_q[log_q.size()-1].busy}, qm[2].size());
    end
    reset = 1'b0;
    run_until_beats(7, 60, "mid_resume");
    total++;
    if (beats.size() < 7 || beats[3][39:38] !== 2'd0 || beats[4][39:36] !== {2'd2, 1'b1, 1'b0}
        || beats[6][39:36] !== {2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL mid_resume_order: q0 not first or queue 2 remainder malformed (beats=%0d)", beats.size());
    end
  endtask

  task automatic test_random();
    for (int round = 0; round < 4; round++) begin
      logic [35:0] src [4][$];
      int plen [4][$];
      beat_t exp_b[$];
      int last = 3;
      int k = 0;
      bit found;
      start_test();
      for (int q = 0; q < 4; q++) begin
        int n = (q == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
        for (int p = 0; p < n; p++) begin
          int len = $urandom_range(1, 6);
          plen[q].push_back(len);
          load_pkt(q, len, 4'($urandom_range(1, 15)));
        end
        src[q] = qm[q];
      end
      drive_inputs();
      // packet-level round robin: next queue after the last served that still holds a packet
      do begin
        found = 1'b0;
        for (int i = 1; i <= 4 && !found; i++) begin
          int idx = (last + i) % 4;
          if (plen[idx].size() > 0) begin
            int len = plen[idx].pop_front();
            for (int w = 0; w < len; w++) begin
              logic [35:0] wd = src[idx].pop_front();
              exp_b.push_back(mk_beat(2'(idx), w == 0, w == len - 1, wd[35:32], wd[31:0]));
            end
            last = idx;
            found = 1'b1;
          end
        end
      end while (found);
      while (beats.size() < exp_b.size() && k < 2000) begin
        dma_rx_rdy = ($urandom_range(0, 3) != 0);
        tick(); k++;
      end
      dma_rx_rdy = 1'b1;
      repeat (5) tick();
      total++;
      if (beats.size() !== exp_b.size()) begin
        bad++; $display("FAIL rand_beat_count: round %0d got %0d want %0d", round, beats.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size(); i++) begin
        total++;
        if (i >= beats.size() || beats[i] !== exp_b[i]) begin
          bad++; $display("FAIL rand_beat: round %0d beat %0d got %h want %h", round, i,
                          i < beats.size() ? beats[i] : '0, exp_b[i]);
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; dma_rx_rdy = 1'b0; force_av = '0;
    d0 = '0; d1 = '0; d2 = '0;
    q_pkt_avail = '0; q_rd_data = '0; q_rd_ctrl = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stale_flag();
    test_abort();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
